// File: rtl/message_loader.sv
// message_loader: byte-serial loader that assembles a secret followed by a
// message from a valid/ready byte stream and presents both as parallel buses,
// holding them with a frame-valid flag until the consumer acknowledges.
module message_loader #(
  parameter int p_message_length = 1,
  parameter int p_secret_length  = 6
) (
  input  logic                            i_w_clk,
  input  logic                            i_w_rst_n,
  input  logic                            i_w_start,
  input  logic                            i_w_byte_valid,
  input  logic [7:0]                      i_w_byte,
  output logic                            o_r_byte_ready,
  input  logic                            i_w_ack,
  output logic [p_message_length*8-1:0]   o_r_text,
  output logic [p_secret_length*8-1:0]    o_r_secret,
  output logic                            o_r_valid,
  output logic                            o_r_busy,
  output logic                            o_r_abort
);

  localparam int MAX_LEN = (p_secret_length > p_message_length) ? p_secret_length : p_message_length;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] SECRET_LAST = CW'(p_secret_length - 1);
  localparam logic [CW-1:0] TEXT_LAST   = CW'(p_message_length - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_SECRET,
    LOAD_TEXT,
    DONE
  } state_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic [p_secret_length*8-1:0]  secret_nxt, secret_shift;
  logic [p_message_length*8-1:0] text_nxt, text_shift;
  logic                          abort_nxt;
  logic                          xfer;

  // A byte moves only when both sides agree; ready mirrors the load states.
  assign xfer     = i_w_byte_valid && o_r_byte_ready;
  assign o_r_busy = o_r_byte_ready;

  // Next-state, counter and bus update logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    secret_nxt   = o_r_secret;
    text_nxt     = o_r_text;
    abort_nxt    = 1'b0;
    // Shift-then-overwrite form stays legal when a length is a single byte.
    secret_shift       = o_r_secret << 8;
    secret_shift[7:0]  = i_w_byte;
    text_shift         = o_r_text << 8;
    text_shift[7:0]    = i_w_byte;

    unique case (state)
      IDLE: begin
        if (i_w_start) begin
          secret_nxt = '0;
          text_nxt   = '0;
          cnt_nxt    = '0;
          state_nxt  = LOAD_SECRET;
        end
      end
      LOAD_SECRET: begin
        if (i_w_start) begin
          secret_nxt = '0;
          text_nxt   = '0;
          cnt_nxt    = '0;
          abort_nxt  = 1'b1;
          state_nxt  = LOAD_SECRET;
        end else if (xfer) begin
          secret_nxt = secret_shift;
          if (cnt == SECRET_LAST) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_TEXT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      LOAD_TEXT: begin
        if (i_w_start) begin
          secret_nxt = '0;
          text_nxt   = '0;
          cnt_nxt    = '0;
          abort_nxt  = 1'b1;
          state_nxt  = LOAD_SECRET;
        end else if (xfer) begin
          text_nxt = text_shift;
          if (cnt == TEXT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DONE: begin
        if (i_w_start) begin
          secret_nxt = '0;
          text_nxt   = '0;
          cnt_nxt    = '0;
          state_nxt  = LOAD_SECRET;
        end else if (i_w_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, buses and registered flags.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      o_r_secret     <= '0;
      o_r_text       <= '0;
      o_r_valid      <= 1'b0;
      o_r_byte_ready <= 1'b0;
      o_r_abort      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      o_r_secret     <= secret_nxt;
      o_r_text       <= text_nxt;
      o_r_valid      <= (state_nxt == DONE);
      o_r_byte_ready <= (state_nxt == LOAD_SECRET) || (state_nxt == LOAD_TEXT);
      o_r_abort      <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_message_loader.sv
// tb_message_loader: directed checks of message_loader with default lengths
// (6-byte secret, 1-byte message) and with a 3-byte message.
module tb_message_loader;

  logic        clk;
  logic        rst_n;
  logic        start, bvalid, ack;
  logic [7:0]  bdata;
  logic        ready, valid, busy, abort;
  logic [7:0]  text;
  logic [47:0] secret;

  logic        start2, bvalid2, ack2;
  logic [7:0]  bdata2;
  logic        ready2, valid2, busy2, abort2;
  logic [23:0] text2;
  logic [47:0] secret2;

  int tests_run = 0;
  int tests_failed = 0;

  message_loader #(.p_message_length(1), .p_secret_length(6)) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start),
    .i_w_byte_valid(bvalid), .i_w_byte(bdata), .o_r_byte_ready(ready),
    .i_w_ack(ack), .o_r_text(text), .o_r_secret(secret),
    .o_r_valid(valid), .o_r_busy(busy), .o_r_abort(abort)
  );

  message_loader #(.p_message_length(3), .p_secret_length(6)) dut3 (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start2),
    .i_w_byte_valid(bvalid2), .i_w_byte(bdata2), .o_r_byte_ready(ready2),
    .i_w_ack(ack2), .o_r_text(text2), .o_r_secret(secret2),
    .o_r_valid(valid2), .o_r_busy(busy2), .o_r_abort(abort2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] DANILA = 48'h44414E494C41;
  localparam logic [7:0]  E_CHR  = 8'h45;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Secret then text, one byte per cycle, optionally with an idle gap after each.
  task automatic send_frame(input logic [47:0] s, input logic [7:0] t, input bit gaps);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) bdata = s[47-8*i -: 8];
      else       bdata = t;
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      if (gaps && i < 6) begin
        bdata  = 8'hFF;
        step();
      end
    end
    bdata = 8'h00;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_text"},   {56'd0, text}, 64'd0);
    check({tag, "_secret"}, {16'd0, secret}, 64'd0);
    check({tag, "_flags"},  {60'd0, valid, busy, ready, abort}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; bvalid = 0; ack = 0; bdata = 0;
    start2 = 0; bvalid2 = 0; ack2 = 0; bdata2 = 0;
    #12;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    step();

    // Back-to-back load; valid must rise on exactly the 7th cycle.
    do_start();
    check("start_ready", {63'd0, ready}, 64'd1);
    check("start_busy",  {63'd0, busy},  64'd1);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) bdata = DANILA[47-8*i -: 8];
      else       bdata = E_CHR;
      bvalid = 1'b1;
      step();
      if (i == 5) check("valid_early", {63'd0, valid}, 64'd0);
    end
    bvalid = 1'b0;
    check("b2b_valid",  {63'd0, valid}, 64'd1);
    check("b2b_secret", {16'd0, secret}, {16'd0, DANILA});
    check("b2b_text",   {56'd0, text},  {56'd0, E_CHR});
    check("done_ready", {62'd0, ready, busy}, 64'd0);

    // Start from DONE: valid drops, no abort; bytes gapped with junk on idle cycles.
    do_start();
    check("redo_valid", {63'd0, valid}, 64'd0);
    check("redo_abort", {63'd0, abort}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      bdata = DANILA[47-8*i -: 8]; bvalid = 1'b1; step();
      bdata = 8'hFF; bvalid = 1'b0; step();
    end
    check("gap_partial", {16'd0, secret}, 64'h0000_0000_0044_414E);
    for (int i = 3; i < 7; i++) begin
      if (i < 6) bdata = DANILA[47-8*i -: 8];
      else       bdata = E_CHR;
      bvalid = 1'b1; step();
      bdata = 8'hFF; bvalid = 1'b0;
      if (i < 6) step();
    end
    check("gap_secret", {16'd0, secret}, {16'd0, DANILA});
    check("gap_text",   {56'd0, text},  {56'd0, E_CHR});
    check("gap_valid",  {63'd0, valid}, 64'd1);

    // Restart mid-load: abort pulse, buses cleared, byte in that cycle dropped.
    ack = 1'b1; step(); ack = 1'b0;
    do_start();
    for (int i = 0; i < 3; i++) begin
      bdata = DANILA[47-8*i -: 8]; bvalid = 1'b1; step();
    end
    start = 1'b1; bdata = 8'h49; bvalid = 1'b1;
    step();
    start = 1'b0; bvalid = 1'b0;
    check("abort_pulse",  {63'd0, abort}, 64'd1);
    check("abort_secret", {16'd0, secret}, 64'd0);
    check("abort_busy",   {63'd0, busy}, 64'd1);
    step();
    check("abort_once",   {63'd0, abort}, 64'd0);
    check("abort_drop",   {16'd0, secret}, 64'd0);
    send_frame(DANILA, E_CHR, 1'b0);
    check("after_abort_secret", {16'd0, secret}, {16'd0, DANILA});
    check("after_abort_text",   {56'd0, text},  {56'd0, E_CHR});

    // Asynchronous reset between edges after four secret bytes.
    ack = 1'b1; step(); ack = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      bdata = DANILA[47-8*i -: 8]; bvalid = 1'b1; step();
    end
    bvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    #1 rst_n = 1'b1;
    step();
    check("rst_idle_busy", {63'd0, busy}, 64'd0);
    do_start();
    send_frame(DANILA, E_CHR, 1'b0);
    check("rst_reload_secret", {16'd0, secret}, {16'd0, DANILA});
    check("rst_reload_valid",  {63'd0, valid}, 64'd1);

    // Hold without ack; then ack; then start+ack together in DONE.
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {63'd0, valid}, 64'd1);
      check("hold_data",  {8'd0, secret, text}, {8'd0, DANILA, E_CHR});
    end
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_valid", {63'd0, valid}, 64'd0);
    check("ack_keep",  {8'd0, secret, text}, {8'd0, DANILA, E_CHR});
    check("ack_idle",  {63'd0, busy}, 64'd0);
    step();
    check("ignored_ack", {63'd0, busy}, 64'd0);
    do_start();
    send_frame(DANILA, E_CHR, 1'b0);
    start = 1'b1; ack = 1'b1; step(); start = 1'b0; ack = 1'b0;
    check("startack_busy",  {63'd0, busy},  64'd1);
    check("startack_valid", {63'd0, valid}, 64'd0);
    check("startack_abort", {63'd0, abort}, 64'd0);
    check("startack_clear", {16'd0, secret}, 64'd0);

    // Three-byte message instance: "KEYABC" + "HEY".
    check("m3_reset", {63'd0, busy2}, 64'd0);
    start2 = 1'b1; step(); start2 = 1'b0;
    begin
      logic [71:0] stream;
      stream = 72'h4B4559414243_484559;
      for (int i = 0; i < 9; i++) begin
        bdata2 = stream[71-8*i -: 8]; bvalid2 = 1'b1; step();
        if (i == 7) check("m3_valid_early", {63'd0, valid2}, 64'd0);
      end
    end
    bvalid2 = 1'b0;
    check("m3_valid",  {63'd0, valid2}, 64'd1);
    check("m3_text",   {40'd0, text2},  64'h484559);
    check("m3_secret", {16'd0, secret2}, 64'h4B4559414243);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
